// File: rtl/serial_byte_packer.sv
// Deserialises a framed MSB-first bit stream, hunts for a header byte and
// writes the following payload bytes into a downstream FIFO.
module serial_byte_packer #(
    parameter logic [7:0]  HEADER_A      = 8'hA5,
    parameter logic [7:0]  HEADER_B      = 8'hC3,
    parameter int unsigned PAYLOAD_BYTES = 4
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       serial_data,
    input  logic       data_ena,
    output logic [7:0] to_fifo_data,
    output logic       wr_fifo,
    output logic       busy,
    output logic       pkt_done,
    output logic       pkt_abort
);

    typedef enum logic {StHdrWait, StPayload} state_t;

    localparam logic [1:0] LastIdx = 2'(PAYLOAD_BYTES - 1);

    state_t     state;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [1:0] byte_cnt;

    logic       byte_rdy;
    logic [7:0] byte_val;
    logic       is_header;

    assign byte_rdy  = data_ena && (bit_cnt == 3'd7);
    assign byte_val  = {shift_reg[6:0], serial_data};
    assign is_header = (byte_val == HEADER_A) || (byte_val == HEADER_B);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StHdrWait;
            shift_reg    <= 8'h00;
            bit_cnt      <= 3'd0;
            byte_cnt     <= 2'd0;
            to_fifo_data <= 8'h00;
            wr_fifo      <= 1'b0;
            busy         <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_abort    <= 1'b0;
        end else begin
            wr_fifo   <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_abort <= 1'b0;

            // Dropping data_ena discards the partial byte and realigns to the next frame.
            if (data_ena) begin
                shift_reg <= byte_val;
                bit_cnt   <= bit_cnt + 3'd1;
            end else begin
                bit_cnt <= 3'd0;
            end

            unique case (state)
                StHdrWait: begin
                    if (byte_rdy && is_header) begin
                        state    <= StPayload;
                        byte_cnt <= 2'd0;
                        busy     <= 1'b1;
                    end
                end
                StPayload: begin
                    if (!data_ena) begin
                        state     <= StHdrWait;
                        byte_cnt  <= 2'd0;
                        busy      <= 1'b0;
                        pkt_abort <= 1'b1;
                    end else if (byte_rdy) begin
                        to_fifo_data <= byte_val;
                        wr_fifo      <= 1'b1;
                        if (byte_cnt == LastIdx) begin
                            state    <= StHdrWait;
                            byte_cnt <= 2'd0;
                            busy     <= 1'b0;
                            pkt_done <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= StHdrWait;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_packer.sv
// Directed bench for serial_byte_packer: expected FIFO writes are queued as
// stimulus is driven and checked by a monitor as the DUT strobes wr_fifo.
`timescale 1ns / 1ps
module tb_serial_byte_packer;

    logic       clk_50      = 1'b0;
    logic       reset_n     = 1'b0;
    logic       serial_data = 1'b0;
    logic       data_ena    = 1'b0;
    logic [7:0] to_fifo_data;
    logic       wr_fifo;
    logic       busy;
    logic       pkt_done;
    logic       pkt_abort;

    serial_byte_packer dut (
        .clk_50       (clk_50),
        .reset_n      (reset_n),
        .serial_data  (serial_data),
        .data_ena     (data_ena),
        .to_fifo_data (to_fifo_data),
        .wr_fifo      (wr_fifo),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .pkt_abort    (pkt_abort)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   wr_times[$];
    int   cyc         = 0;
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   wr_count    = 0;
    int   abort_count = 0;
    int   busy_rise   = -1;
    int   busy_fall   = -1;
    logic busy_prev   = 1'b0;

    always @(posedge clk_50) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write, sampling on the falling edge.
    always @(negedge clk_50) begin
        if (reset_n) begin
            if (wr_fifo) begin
                wr_count++;
                wr_times.push_back(cyc);
                check("write_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e_cur = sb.pop_front();
                    check("wr_data", 32'(to_fifo_data), 32'(e_cur.data));
                    check("done_on_last_write", 32'(pkt_done), 32'(e_cur.last));
                end
            end else if (pkt_done) begin
                check("done_needs_write", 32'(wr_fifo), 32'd1);
            end
            if (pkt_abort) abort_count++;
            if (busy && !busy_prev) busy_rise = cyc;
            if (!busy && busy_prev) busy_fall = cyc;
            busy_prev = busy;
        end else begin
            busy_prev = 1'b0;
        end
    end

    task automatic send_bit(input logic b);
        serial_data = b;
        data_ena    = 1'b1;
        @(posedge clk_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic idle(input int n);
        data_ena    = 1'b0;
        serial_data = 1'b0;
        repeat (n) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic expect_pkt(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        sb.push_back('{data: b0, last: 1'b0});
        sb.push_back('{data: b1, last: 1'b0});
        sb.push_back('{data: b2, last: 1'b0});
        sb.push_back('{data: b3, last: 1'b1});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, 32'(to_fifo_data), 32'd0);
        check({tag, "_wr"}, 32'(wr_fifo), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(pkt_done), 32'd0);
        check({tag, "_abort"}, 32'(pkt_abort), 32'd0);
    endtask

    int t0;
    int wr_base;
    int ab_base;

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk_50);
        #1;
        check_outputs_zero("por");
        reset_n = 1'b1;
        idle(2);

        // Nominal packet with timing: first header bit is sampled on edge t0+1.
        wr_times.delete();
        wr_base = wr_count;
        ab_base = abort_count;
        expect_pkt(8'h11, 8'h22, 8'h33, 8'h44);
        t0 = cyc;
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        idle(2);
        check("nom_writes", 32'(wr_count - wr_base), 32'd4);
        if (wr_times.size() == 4) begin
            // Each write is visible in the cycle after its byte's eighth bit edge.
            check("nom_wr0_time", 32'(wr_times[0] - t0), 32'd16);
            check("nom_wr1_time", 32'(wr_times[1] - t0), 32'd24);
            check("nom_wr2_time", 32'(wr_times[2] - t0), 32'd32);
            check("nom_wr3_time", 32'(wr_times[3] - t0), 32'd40);
        end
        check("nom_busy_rise", 32'(busy_rise - t0), 32'd8);
        check("nom_busy_fall", 32'(busy_fall - t0), 32'd40);
        check("nom_no_abort", 32'(abort_count - ab_base), 32'd0);
        check("nom_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-packet, then a packet straight out of reset.
        send_byte(8'hA5);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("rst_busy_before", 32'(busy), 32'd1);
        #5;
        reset_n  = 1'b0;
        data_ena = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        @(posedge clk_50);
        #1;
        check_outputs_zero("rst_hold");
        reset_n = 1'b1;
        wr_base = wr_count;
        expect_pkt(8'h11, 8'h22, 8'h33, 8'h44);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        idle(2);
        check("rst_post_writes", 32'(wr_count - wr_base), 32'd4);
        check("rst_sb_empty", 32'(sb.size()), 32'd0);

        // Header hunt with leading junk bytes and the alternate header.
        wr_base = wr_count;
        expect_pkt(8'h01, 8'h02, 8'h03, 8'h04);
        send_byte(8'h00);
        send_byte(8'h7F);
        check("hunt_idle_busy", 32'(busy), 32'd0);
        send_byte(8'hC3);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        idle(2);
        check("hunt_writes", 32'(wr_count - wr_base), 32'd4);

        // Header values inside the payload are data.
        wr_base = wr_count;
        ab_base = abort_count;
        expect_pkt(8'hA5, 8'hC3, 8'hA5, 8'hFF);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'hC3);
        send_byte(8'hA5);
        send_byte(8'hFF);
        check("hdrdata_busy_after", 32'(busy), 32'd0);
        idle(2);
        check("hdrdata_writes", 32'(wr_count - wr_base), 32'd4);
        check("hdrdata_no_abort", 32'(abort_count - ab_base), 32'd0);

        // Truncated packet, then a normal one.
        wr_base = wr_count;
        ab_base = abort_count;
        sb.push_back('{data: 8'h10, last: 1'b0});
        sb.push_back('{data: 8'h20, last: 1'b0});
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h20);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(1);
        check("trunc_abort_pulse", 32'(pkt_abort), 32'd1);
        check("trunc_busy", 32'(busy), 32'd0);
        idle(1);
        check("trunc_abort_one_cycle", 32'(pkt_abort), 32'd0);
        check("trunc_writes", 32'(wr_count - wr_base), 32'd2);
        check("trunc_abort_count", 32'(abort_count - ab_base), 32'd1);
        wr_base = wr_count;
        expect_pkt(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h6B);
        send_byte(8'h7C);
        send_byte(8'h8D);
        idle(2);
        check("trunc_next_writes", 32'(wr_count - wr_base), 32'd4);

        // Misalignment: partial header bits are discarded when data_ena drops.
        wr_base = wr_count;
        ab_base = abort_count;
        expect_pkt(8'h01, 8'h02, 8'h03, 8'h04);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        idle(1);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        idle(3);
        check("misalign_writes", 32'(wr_count - wr_base), 32'd4);
        check("misalign_no_abort", 32'(abort_count - ab_base), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
